seg7_scan_decoder: RTL and testbench
====================================

// Module: seg7_scan_decoder
// PURPOSE
//  Reader for the watch's multiplexed 4-digit 7-segment output. Samples the anode and cathode buses,
//  decodes each digit phase back to BCD, assembles MM:SS frames and, once a frame is confirmed
//  stable, publishes binary minutes/seconds. Used for display loopback checking and self-test.
// PARAMETERS
//  SETTLE_CYCLES   16  consecutive clk cycles an anode phase must hold before its cathode is sampled
//  CONFIRM_FRAMES  2   identical consecutive frames required before outputs update (>=1)
// PORTS
//  clk               in   1  system clock
//  reset             in   1  asynchronous, active-high reset
//  Anode_Activate    in   4  active-low digit select; 0111=min tens, 1011=min ones, 1101=sec tens, 1110=sec ones
//  Cathode_Activate  in   7  active-low segments, bit6=a ... bit0=g
//  min               out  6  decoded minutes, 0..59
//  sec               out  6  decoded seconds, 0..59
//  frame_valid       out  1  1-cycle pulse when min/sec update
//  digit_err         out  1  1-cycle pulse: cathode not a legal digit, or tens digit >5
//  seq_err           out  1  1-cycle pulse: anode phase out of order, or more than one anode low
// BEHAVIOUR
//  - Reset: min=0, sec=0, all pulses 0, settle counter 0, confirm counter 0, state SYNC, frame buffer cleared.
//  - Digit table (cathode->BCD): 0000001=0 1001111=1 0010010=2 0000110=3 1001100=4
//    0100100=5 0100000=6 0001111=7 0000000=8 0000100=9; any other pattern -> digit_err.
//  - Settle: counter increments while Anode_Activate equals its previous-cycle value and is a legal
//    one-low code; it clears on any change. Exactly one sample per phase, taken on the cycle the
//    count reaches SETTLE_CYCLES; counter then saturates until the phase changes.
//  - Anode 1111 (blank): ignored, settle counter cleared, sequence position kept.
//  - Anode with two or more bits low: seq_err pulse, frame discarded, state -> SYNC.
//  - FSM: SYNC -> D0 when phase 0111 is sampled (digit stored); D0->D1->D2->D3 on samples of
//    1011, 1101, 1110 respectively. A sampled phase other than the expected one -> seq_err, discard;
//    if that phase is 0111 it is taken as a new D0, else state -> SYNC.
//    SYNC discards samples of phases other than 0111 silently (no seq_err).
//  - Illegal cathode or tens digit >5: digit_err pulse on sample cycle+1, frame discarded, confirm
//    counter cleared, state -> SYNC.
//  - Frame complete at D3 sample: min=tens*10+ones (6-bit, max 59), same for sec. If frame equals
//    previous complete frame, confirm counter increments (saturating), else it restarts at 1.
//    When the counter reaches CONFIRM_FRAMES, outputs load and frame_valid pulses on the cycle after
//    the D3 sample. Further identical frames pulse frame_valid again only if the value differs from
//    the published min/sec. State returns to SYNC, awaiting next 0111.
//  - Error and frame_valid never pulse in the same cycle; errors take priority.
//  - min/sec hold their last published value through errors and blanking; only reset clears them.
//  - Reset asserted mid-frame: everything returns to reset values immediately; no partial output.
// CONFIGURATION
//  SEG7_SCAN_SYNC_EN defined: Anode_Activate and Cathode_Activate pass through a 2-flop synchronizer
//    (reset value 1111 / 1111111) before use; all latencies grow by 2 clk cycles.
//  Not defined: inputs used directly (same-clock-domain source); latencies as stated above.
// TESTING
//  1. Drive frame 12:34, each phase 20 cycles, repeat 2x -> frame_valid once, min=12, sec=34.
//  2. Frame 59:59 then 00:00, each sent 2x -> min/sec 59/59 then 0/0, two frame_valid pulses.
//  3. Phase held only 10 cycles (< SETTLE_CYCLES) -> no sample, no frame_valid, outputs unchanged.
//  4. Cathode 1111111 on D2 phase -> digit_err pulse, no update; next two clean frames -> update.
//  5. Phases in order 0111,1101 -> seq_err; anode 0011 -> seq_err; min/sec unchanged.
//  6. Reset asserted during D2 of a frame -> outputs 0 at once; frame after release needs full
//     CONFIRM_FRAMES sequence before frame_valid.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// Reads back a multiplexed 4-digit 7-segment scan (MM:SS), checks phase order and digit legality,
// and publishes binary minutes/seconds once a frame repeats. Define SEG7_SCAN_SYNC_EN to add input synchronizers.
module seg7_scan_decoder #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int CONFIRM_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Anode_Activate,
  input  logic [6:0] Cathode_Activate,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       frame_valid,
  output logic       digit_err,
  output logic       seq_err
);
  localparam int SCW = $clog2(SETTLE_CYCLES + 1);
  localparam int CCW = $clog2(CONFIRM_FRAMES + 1);
  localparam logic [SCW-1:0] SETTLE_MAX = SCW'(SETTLE_CYCLES);
  localparam logic [SCW-1:0] SETTLE_HIT = SCW'(SETTLE_CYCLES - 1);
  localparam logic [CCW-1:0] CONF_MAX   = CCW'(CONFIRM_FRAMES);

  // A D3 sample completes the frame in the same cycle, so no D3 state is ever held.
  typedef enum logic [1:0] {SYNC, D0, D1, D2} state_t;

  logic [3:0] an;
  logic [6:0] ca;

`ifdef SEG7_SCAN_SYNC_EN
  logic [3:0] an_s1_q, an_s2_q;
  logic [6:0] ca_s1_q, ca_s2_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_s1_q <= 4'hF;
      an_s2_q <= 4'hF;
      ca_s1_q <= 7'h7F;
      ca_s2_q <= 7'h7F;
    end else begin
      an_s1_q <= Anode_Activate;
      an_s2_q <= an_s1_q;
      ca_s1_q <= Cathode_Activate;
      ca_s2_q <= ca_s1_q;
    end
  end
  assign an = an_s2_q;
  assign ca = ca_s2_q;
`else
  assign an = Anode_Activate;
  assign ca = Cathode_Activate;
`endif

  function automatic logic [4:0] seg_decode(input logic [6:0] c);
    case (c)
      7'b0000001: return {1'b1, 4'd0};
      7'b1001111: return {1'b1, 4'd1};
      7'b0010010: return {1'b1, 4'd2};
      7'b0000110: return {1'b1, 4'd3};
      7'b1001100: return {1'b1, 4'd4};
      7'b0100100: return {1'b1, 4'd5};
      7'b0100000: return {1'b1, 4'd6};
      7'b0001111: return {1'b1, 4'd7};
      7'b0000000: return {1'b1, 4'd8};
      7'b0000100: return {1'b1, 4'd9};
      default:    return 5'b0;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       an_prev_q;
  logic [SCW-1:0]   cnt_q, cnt_d;
  logic [2:0][3:0]  dig_q, dig_d;
  logic [CCW-1:0]   conf_q, conf_d, conf_nx;
  logic             pf_vld_q, pf_vld_d;
  logic [5:0]       pmin_q, pmin_d, psec_q, psec_d;
  logic [5:0]       min_q, min_d, sec_q, sec_d;
  logic             fv_q, fv_d, de_q, de_d, se_q, se_d;

  logic       one_low, stable, sample, multi_new, tens_bad, take, same, pub;
  logic [1:0] ph, exp_ph;
  logic [4:0] dv;
  logic [5:0] fmin, fsec;

  always_comb begin
    one_low = 1'b1;
    ph      = 2'd0;
    case (an)
      4'b0111: ph = 2'd0;
      4'b1011: ph = 2'd1;
      4'b1101: ph = 2'd2;
      4'b1110: ph = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  assign stable    = (an == an_prev_q);
  assign sample    = one_low && stable && (cnt_q == SETTLE_HIT);
  assign multi_new = !one_low && (an != 4'hF) && !stable;
  assign exp_ph    = state_q;

  always_comb begin
    cnt_d = '0;
    if (one_low && stable)
      cnt_d = (cnt_q == SETTLE_MAX) ? cnt_q : cnt_q + SCW'(1);
  end

  always_comb begin
    state_d  = state_q;
    dig_d    = dig_q;
    conf_d   = conf_q;
    pf_vld_d = pf_vld_q;
    pmin_d   = pmin_q;
    psec_d   = psec_q;
    min_d    = min_q;
    sec_d    = sec_q;
    fv_d     = 1'b0;
    de_d     = 1'b0;
    se_d     = 1'b0;

    dv       = seg_decode(ca);
    tens_bad = !ph[0] && (dv[3:0] > 4'd5);
    take     = (ph == exp_ph) || (ph == 2'd0);
    fmin     = 6'(dig_q[0]) * 6'd10 + 6'(dig_q[1]);
    fsec     = 6'(dig_q[2]) * 6'd10 + 6'(dv[3:0]);
    same     = pf_vld_q && (fmin == pmin_q) && (fsec == psec_q);
    conf_nx  = !same ? CCW'(1) : ((conf_q == CONF_MAX) ? conf_q : conf_q + CCW'(1));
    // A saturated repeat only republishes if it disagrees with what is on the outputs.
    pub      = (conf_nx == CONF_MAX) &&
               (!same || (conf_q != CONF_MAX) || (fmin != min_q) || (fsec != sec_q));

    if (multi_new) begin
      se_d    = 1'b1;
      state_d = SYNC;
    end else if (sample && !(state_q == SYNC && ph != 2'd0)) begin
      if (ph != exp_ph) begin
        se_d    = 1'b1;
        state_d = SYNC;
      end
      if (take) begin
        if (!dv[4] || tens_bad) begin
          de_d    = 1'b1;
          conf_d  = '0;
          state_d = SYNC;
        end else begin
          case (ph)
            2'd0: begin dig_d[0] = dv[3:0]; state_d = D0; end
            2'd1: begin dig_d[1] = dv[3:0]; state_d = D1; end
            2'd2: begin dig_d[2] = dv[3:0]; state_d = D2; end
            default: begin
              state_d  = SYNC;
              conf_d   = conf_nx;
              pf_vld_d = 1'b1;
              pmin_d   = fmin;
              psec_d   = fsec;
              if (pub) begin
                min_d = fmin;
                sec_d = fsec;
                fv_d  = 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SYNC;
      an_prev_q <= 4'hF;
      cnt_q     <= '0;
      dig_q     <= '0;
      conf_q    <= '0;
      pf_vld_q  <= 1'b0;
      pmin_q    <= '0;
      psec_q    <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      fv_q      <= 1'b0;
      de_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      an_prev_q <= an;
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      conf_q    <= conf_d;
      pf_vld_q  <= pf_vld_d;
      pmin_q    <= pmin_d;
      psec_q    <= psec_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      fv_q      <= fv_d;
      de_q      <= de_d;
      se_q      <= se_d;
    end
  end

  assign min         = min_q;
  assign sec         = sec_q;
  assign frame_valid = fv_q;
  assign digit_err   = de_q;
  assign seq_err     = se_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: vector table of whole frames, hand corner sequences, random frames,
// with a per-cycle reference model of the scan reader running alongside.
module tb_seg7_scan_decoder;
  localparam int SETTLE = 16;
  localparam int CONF   = 2;
  localparam logic [3:0] PH  [4]  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  localparam logic [6:0] SEG [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                      7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] an  = 4'hF;
  logic [6:0] ca  = 7'h7F;
  logic [5:0] min, sec;
  logic       fv, de, se;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.SETTLE_CYCLES(SETTLE), .CONFIRM_FRAMES(CONF)) dut (
    .clk(clk), .reset(rst), .Anode_Activate(an), .Cathode_Activate(ca),
    .min(min), .sec(sec), .frame_valid(fv), .digit_err(de), .seq_err(se)
  );

  int checks = 0, failures = 0;
  int fv_n = 0, de_n = 0, se_n = 0;

  // Reference model: run length of each anode value, digits collected so far, last complete frame.
  logic [3:0] m_last, a1, a2;
  logic [6:0] c1, c2;
  int run, nxt, pm, ps, conf, em, es;
  int digs[4];
  bit have_prev, efv, ede, ese;

  function automatic int phase_of(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (PH[i] == a) return i;
    return -1;
  endfunction

  function automatic int digit_of(input logic [6:0] c);
    for (int i = 0; i < 10; i++) if (SEG[i] == c) return i;
    return -1;
  endfunction

  task model_reset();
    m_last = 4'hF; a1 = 4'hF; a2 = 4'hF; c1 = 7'h7F; c2 = 7'h7F;
    run = 0; nxt = 0; pm = 0; ps = 0; conf = 0; em = 0; es = 0;
    for (int i = 0; i < 4; i++) digs[i] = 0;
    have_prev = 0; efv = 0; ede = 0; ese = 0;
  endtask

  task model_step();
    logic [3:0] a;
    logic [6:0] c;
    int ph, d, m, s, old;
    bit same, take;
`ifdef SEG7_SCAN_SYNC_EN
    a = a2; c = c2; a2 = a1; c2 = c1; a1 = an; c1 = ca;
`else
    a = an; c = ca;
`endif
    efv = 0; ede = 0; ese = 0;
    run = (a == m_last) ? run + 1 : 1;
    m_last = a;
    ph = phase_of(a);
    if (ph < 0 && a != 4'hF && run == 1) begin
      ese = 1; nxt = 0;
    end
    if (ph >= 0 && run == SETTLE + 1 && !(nxt == 0 && ph != 0)) begin
      d = digit_of(c);
      take = (ph == nxt) || (ph == 0);
      if (ph != nxt) begin ese = 1; nxt = 0; end
      if (take) begin
        if (d < 0 || (ph % 2 == 0 && d > 5)) begin
          ede = 1; conf = 0; nxt = 0;
        end else begin
          digs[ph] = d;
          if (ph < 3) nxt = ph + 1;
          else begin
            m = digs[0] * 10 + digs[1];
            s = digs[2] * 10 + digs[3];
            same = have_prev && m == pm && s == ps;
            old = conf;
            conf = same ? ((conf < CONF) ? conf + 1 : CONF) : 1;
            have_prev = 1; pm = m; ps = s;
            if (conf >= CONF && (old < CONF || !same || m != em || s != es)) begin
              em = m; es = s; efv = 1;
            end
            nxt = 0;
          end
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    checks++;
    if ({min, sec, fv, de, se} !== {6'(em), 6'(es), efv, ede, ese}) begin
      failures++;
      $display("FAIL cycle t=%0t got min=%0d sec=%0d fv=%b de=%b se=%b expected min=%0d sec=%0d fv=%b de=%b se=%b",
               $time, min, sec, fv, de, se, em, es, efv, ede, ese);
    end
    if (fv === 1'b1) fv_n++;
    if (de === 1'b1) de_n++;
    if (se === 1'b1) se_n++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] a, input logic [6:0] c, input int n);
    repeat (n) begin
      @(negedge clk);
      an = a; ca = c;
    end
  endtask

  task automatic send_frame(input int m, input int s, input int hold, input int bad, input logic [6:0] badc);
    int dg[4];
    dg = '{m / 10, m % 10, s / 10, s % 10};
    for (int i = 0; i < 4; i++) step(PH[i], (i == bad) ? badc : SEG[dg[i]], hold);
  endtask

  // Blank gap lets trailing pulses land, then counters are sampled clear of the edge.
  task automatic settle_and_clear();
    step(4'hF, 7'h7F, 5);
    #2;
  endtask

  task automatic clear_counts();
    fv_n = 0; de_n = 0; se_n = 0;
  endtask

  typedef struct {
    int m, s, reps, hold, bad;
    int exp_min, exp_sec, exp_fv, exp_de, exp_se;
  } vec_t;

  vec_t tv[13];

  initial begin
    tv[0]  = '{12, 34, 2, 20, -1, 12, 34, 1, 0, 0};
    tv[1]  = '{59, 59, 2, 20, -1, 59, 59, 1, 0, 0};
    tv[2]  = '{ 0,  0, 2, 20, -1,  0,  0, 1, 0, 0};
    tv[3]  = '{ 7,  5, 1, 20, -1,  0,  0, 0, 0, 0};
    tv[4]  = '{ 7,  5, 1, 20, -1,  7,  5, 1, 0, 0};
    tv[5]  = '{ 7,  5, 3, 20, -1,  7,  5, 0, 0, 0};
    tv[6]  = '{12, 34, 2, 10, -1,  7,  5, 0, 0, 0};
    tv[7]  = '{ 1,  2, 2, 16, -1,  7,  5, 0, 0, 0};
    tv[8]  = '{45, 30, 2, 17, -1, 45, 30, 1, 0, 0};
    tv[9]  = '{21, 43, 1, 20,  2, 45, 30, 0, 1, 0};
    tv[10] = '{21, 43, 2, 20, -1, 21, 43, 1, 0, 0};
    tv[11] = '{75, 10, 1, 20, -1, 21, 43, 0, 1, 0};
    tv[12] = '{30, 61, 1, 20, -1, 21, 43, 0, 1, 0};

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_min", min, 0);
    chk("reset_sec", sec, 0);
    chk("reset_pulses", {29'd0, fv, de, se}, 0);
    @(negedge clk);
    rst = 1'b0;
    settle_and_clear();
    clear_counts();

    for (int v = 0; v < 13; v++) begin
      for (int r = 0; r < tv[v].reps; r++) send_frame(tv[v].m, tv[v].s, tv[v].hold, tv[v].bad, 7'h7F);
      settle_and_clear();
      chk($sformatf("vec%0d_min", v), min, tv[v].exp_min);
      chk($sformatf("vec%0d_sec", v), sec, tv[v].exp_sec);
      chk($sformatf("vec%0d_fv", v), fv_n, tv[v].exp_fv);
      chk($sformatf("vec%0d_de", v), de_n, tv[v].exp_de);
      chk($sformatf("vec%0d_se", v), se_n, tv[v].exp_se);
      clear_counts();
    end

    // Phase skipped, then two anodes low at once.
    step(PH[0], SEG[1], 20);
    step(PH[2], SEG[2], 20);
    settle_and_clear();
    chk("skip_se", se_n, 1);
    step(4'b0011, 7'h7F, 5);
    settle_and_clear();
    chk("multi_se", se_n, 2);
    chk("seq_min_hold", min, 21);
    chk("seq_sec_hold", sec, 43);
    clear_counts();

    // Blank inserted mid-frame keeps the sequence position.
    repeat (2) begin
      step(PH[0], SEG[3], 20); step(PH[1], SEG[3], 20);
      step(4'hF, 7'h7F, 4);
      step(PH[2], SEG[4], 20); step(PH[3], SEG[4], 20);
    end
    settle_and_clear();
    chk("blank_fv", fv_n, 1);
    chk("blank_min", min, 33);
    chk("blank_sec", sec, 44);
    clear_counts();

    // Reset during the D2 phase.
    step(PH[0], SEG[1], 20); step(PH[1], SEG[8], 20); step(PH[2], SEG[2], 18);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset_min", min, 0);
    chk("midreset_sec", sec, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    settle_and_clear();
    clear_counts();
    send_frame(33, 44, 20, -1, 7'h7F);
    settle_and_clear();
    chk("postreset_fv1", fv_n, 0);
    chk("postreset_min1", min, 0);
    send_frame(33, 44, 20, -1, 7'h7F);
    settle_and_clear();
    chk("postreset_fv2", fv_n, 1);
    chk("postreset_min2", min, 33);
    chk("postreset_sec2", sec, 44);

    // Random frames, checked cycle by cycle against the model.
    for (int k = 0; k < 25; k++) begin
      int m, s, reps, bad;
      m = $urandom_range(0, 59);
      s = $urandom_range(0, 59);
      reps = $urandom_range(1, 3);
      for (int r = 0; r < reps; r++) begin
        bad = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1;
        send_frame(m, s, $urandom_range(14, 22), bad, 7'($urandom));
        if ($urandom_range(0, 9) == 0) step(4'($urandom), 7'($urandom), $urandom_range(1, 4));
        if ($urandom_range(0, 4) == 0) step(4'hF, 7'h7F, $urandom_range(1, 6));
      end
    end
    settle_and_clear();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
